cue_ball_motion: RTL and testbench

//  Receiving end of the shot interface. Accepts newVelocityX/Y when velocityWriteEnable is

---
 rtl/billiard_pkg.sv | 26 ++
 rtl/axis_integrator.sv | 65 ++++++
 rtl/cue_ball_motion.sv | 95 +++++++++
 tb/tb_cue_ball_motion.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/billiard_pkg.sv
// rtl/billiard_pkg.sv - shared cue-ball types, table bounds and motion defaults
package billiard_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    MOVING = 1'b1
  } ball_state_t;

  localparam int DEFAULT_FRAC_BITS       = 6;
  localparam int DEFAULT_FRICTION_PERIOD = 4;

  localparam int SPAWN_X = 200;
  localparam int SPAWN_Y = 240;

  localparam int TABLE_X_MIN = 32;
  localparam int TABLE_X_MAX = 592;
  localparam int TABLE_Y_MIN = 32;
  localparam int TABLE_Y_MAX = 448;

  localparam int PIX_W = 11;
  localparam int VEL_W = 11;

  // Largest shot magnitude the aiming block may commit; negation must stay in VEL_W.
  localparam int VELOCITY_LIMIT = 200;

endpackage

// File: rtl/axis_integrator.sv
// rtl/axis_integrator.sv - one axis of fixed-point cue-ball motion
// Adds velocity once per frame, clamps to the table edge with a bounce, then applies friction.
module axis_integrator #(
  parameter int FRAC_BITS = 6,
  parameter int MIN_POS   = 32,
  parameter int MAX_POS   = 592,
  parameter int INIT_POS  = 200,
  parameter int VEL_W     = 11,
  parameter int PIX_W     = 11
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    respawn,
  input  logic                    load,
  input  logic signed [VEL_W-1:0] loadVel,
  input  logic                    step,
  input  logic                    frictionTick,
  output logic        [PIX_W-1:0] topLeft,
  output logic signed [VEL_W-1:0] velNext
);

  localparam int POS_W = 12 + FRAC_BITS;
  localparam logic signed [POS_W-1:0] MIN_FX  = POS_W'(MIN_POS << FRAC_BITS);
  localparam logic signed [POS_W-1:0] MAX_FX  = POS_W'(MAX_POS << FRAC_BITS);
  localparam logic signed [POS_W-1:0] INIT_FX = POS_W'(INIT_POS << FRAC_BITS);

  logic signed [POS_W-1:0] pos, posSum, posNext;
  logic signed [VEL_W-1:0] vel, velBounced;

  always_comb begin
    posSum     = pos + POS_W'(vel);
    posNext    = posSum;
    velBounced = vel;
    if (posSum < MIN_FX) begin
      posNext    = MIN_FX;
      velBounced = -vel;
    end else if (posSum > MAX_FX) begin
      posNext    = MAX_FX;
      velBounced = -vel;
    end
    // Friction acts on the post-bounce velocity so a wall hit cannot undo it.
    velNext = velBounced;
    if (frictionTick && velBounced != '0) begin
      velNext = velBounced[VEL_W-1] ? velBounced + VEL_W'(1) : velBounced - VEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pos <= INIT_FX;
      vel <= '0;
    end else if (respawn) begin
      pos <= INIT_FX;
      vel <= '0;
    end else if (load) begin
      vel <= loadVel;
    end else if (step) begin
      pos <= posNext;
      vel <= velNext;
    end
  end

  assign topLeft = pos[FRAC_BITS+PIX_W-1:FRAC_BITS];

endmodule

// File: rtl/cue_ball_motion.sv
// rtl/cue_ball_motion.sv - cue-ball shot acceptance, per-frame integration and idle detect
// Owns the IDLE/MOVING FSM, the friction frame counter and the shotAccepted pulse.
module cue_ball_motion
  import billiard_pkg::*;
#(
  parameter int INIT_X          = SPAWN_X,
  parameter int INIT_Y          = SPAWN_Y,
  parameter int X_MIN           = TABLE_X_MIN,
  parameter int X_MAX           = TABLE_X_MAX,
  parameter int Y_MIN           = TABLE_Y_MIN,
  parameter int Y_MAX           = TABLE_Y_MAX,
  parameter int FRAC_BITS       = DEFAULT_FRAC_BITS,
  parameter int FRICTION_PERIOD = DEFAULT_FRICTION_PERIOD
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    velocityWriteEnable,
  input  logic signed [VEL_W-1:0] newVelocityX,
  input  logic signed [VEL_W-1:0] newVelocityY,
  input  logic                    ballInPocket,
  output logic        [PIX_W-1:0] topLeftX,
  output logic        [PIX_W-1:0] topLeftY,
  output logic                    ballIdle,
  output logic                    shotAccepted
);

  localparam int CNT_W = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;

  ball_state_t state, stateNext;
  logic [CNT_W-1:0] frameCnt, frameCntNext;
  logic shotAccept, frameUpdate, frictionTick, stopNow;
  logic signed [VEL_W-1:0] velXNext, velYNext;

  always_comb begin
    shotAccept   = (state == IDLE) && velocityWriteEnable && !ballInPocket &&
                   (newVelocityX != '0 || newVelocityY != '0);
    frameUpdate  = (state == MOVING) && startOfFrame && !ballInPocket;
    frameCntNext = (frameCnt == CNT_W'(FRICTION_PERIOD - 1)) ? '0 : frameCnt + CNT_W'(1);
    frictionTick = frameUpdate && (frameCntNext == '0);
    stopNow      = frameUpdate && (velXNext == '0) && (velYNext == '0);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (ballInPocket) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (shotAccept) stateNext = MOVING;
        MOVING:  if (stopNow)    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    ballIdle = (state == IDLE);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameCnt     <= '0;
      shotAccepted <= 1'b0;
    end else begin
      shotAccepted <= shotAccept;
      if (ballInPocket || shotAccept) frameCnt <= '0;
      else if (frameUpdate)           frameCnt <= frameCntNext;
    end
  end

  axis_integrator #(
    .FRAC_BITS(FRAC_BITS), .MIN_POS(X_MIN), .MAX_POS(X_MAX), .INIT_POS(INIT_X),
    .VEL_W(VEL_W), .PIX_W(PIX_W)
  ) axisX (
    .clk(clk), .resetN(resetN), .respawn(ballInPocket), .load(shotAccept),
    .loadVel(newVelocityX), .step(frameUpdate), .frictionTick(frictionTick),
    .topLeft(topLeftX), .velNext(velXNext)
  );

  axis_integrator #(
    .FRAC_BITS(FRAC_BITS), .MIN_POS(Y_MIN), .MAX_POS(Y_MAX), .INIT_POS(INIT_Y),
    .VEL_W(VEL_W), .PIX_W(PIX_W)
  ) axisY (
    .clk(clk), .resetN(resetN), .respawn(ballInPocket), .load(shotAccept),
    .loadVel(newVelocityY), .step(frameUpdate), .frictionTick(frictionTick),
    .topLeft(topLeftY), .velNext(velYNext)
  );

endmodule

// File: tb/tb_cue_ball_motion.sv
// tb/tb_cue_ball_motion.sv - directed scoreboard bench for cue_ball_motion
module tb_cue_ball_motion;

  logic clk = 1'b0;
  logic resetN, startOfFrame, velocityWriteEnable, ballInPocket;
  logic signed [10:0] newVelocityX, newVelocityY;
  logic [10:0] topLeftX, topLeftY;
  logic ballIdle, shotAccepted;

  always #5 clk = ~clk;

  cue_ball_motion dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .velocityWriteEnable(velocityWriteEnable), .newVelocityX(newVelocityX),
    .newVelocityY(newVelocityY), .ballInPocket(ballInPocket),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .ballIdle(ballIdle), .shotAccepted(shotAccepted)
  );

  typedef struct {
    int    x;
    int    y;
    int    idle;
    string tag;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int mPosX, mPosY, mVelX, mVelY, mCnt, mIdle;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mPosX = 200 * 64; mPosY = 240 * 64;
    mVelX = 0; mVelY = 0; mCnt = 0; mIdle = 1;
  endtask

  function automatic void axisStep(inout int p, inout int v, input int lo, input int hi);
    int n;
    n = p + v;
    if (n < lo * 64) begin
      p = lo * 64; v = -v;
    end else if (n > hi * 64) begin
      p = hi * 64; v = -v;
    end else begin
      p = n;
    end
  endfunction

  function automatic int towardZero(input int v);
    if (v > 0) return v - 1;
    if (v < 0) return v + 1;
    return 0;
  endfunction

  task automatic modelFrame();
    if (!mIdle) begin
      axisStep(mPosX, mVelX, 32, 592);
      axisStep(mPosY, mVelY, 32, 448);
      mCnt = (mCnt + 1) % 4;
      if (mCnt == 0) begin
        mVelX = towardZero(mVelX);
        mVelY = towardZero(mVelY);
      end
      if (mVelX == 0 && mVelY == 0) mIdle = 1;
    end
  endtask

  task automatic popCompare();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      check({e.tag, "_x"}, 32'(topLeftX), e.x);
      check({e.tag, "_y"}, 32'(topLeftY), e.y);
      check({e.tag, "_idle"}, 32'(ballIdle), e.idle);
    end
  endtask

  task automatic frame(input string tag);
    startOfFrame = 1'b1;
    modelFrame();
    sb.push_back('{mPosX / 64, mPosY / 64, mIdle, tag});
    tick();
    startOfFrame = 1'b0;
    popCompare();
  endtask

  task automatic shoot(input string tag, input int vx, input int vy, input logic sof);
    int acc;
    acc = (mIdle != 0 && (vx != 0 || vy != 0)) ? 1 : 0;
    velocityWriteEnable = 1'b1;
    newVelocityX = 11'(vx);
    newVelocityY = 11'(vy);
    startOfFrame = sof;
    if (acc != 0) begin
      mVelX = vx; mVelY = vy; mCnt = 0; mIdle = 0;
    end else if (sof) begin
      modelFrame();
    end
    sb.push_back('{mPosX / 64, mPosY / 64, mIdle, tag});
    tick();
    velocityWriteEnable = 1'b0;
    startOfFrame = 1'b0;
    newVelocityX = '0;
    newVelocityY = '0;
    check({tag, "_pulse"}, 32'(shotAccepted), acc);
    popCompare();
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    velocityWriteEnable = 1'b0;
    ballInPocket = 1'b0;
    newVelocityX = '0;
    newVelocityY = '0;
    modelReset();
    tick();
    tick();
    check("rst_x", 32'(topLeftX), 200);
    check("rst_y", 32'(topLeftY), 240);
    check("rst_idle", 32'(ballIdle), 1);
    check("rst_pulse", 32'(shotAccepted), 0);
    resetN = 1'b1;
    tick();

    shoot("zero_write", 0, 0, 1'b0);

    // Concurrent frame pulse must not move the ball on the accept cycle.
    shoot("shot64", 64, 0, 1'b1);
    check("shot64_x_hold", 32'(topLeftX), 200);
    tick();
    check("shot64_pulse_width", 32'(shotAccepted), 0);
    frame("f1");
    check("f1_x_const", 32'(topLeftX), 201);
    frame("f2");
    frame("f3");
    frame("f4");
    frame("f5");
    check("f5_x_friction", 32'(topLeftX), 204);
    frame("f6");
    check("f6_x_const", 32'(topLeftX), 205);
    shoot("write_moving", 10, 10, 1'b0);
    frame("f7");
    check("f7_x_const", 32'(topLeftX), 206);

    resetN = 1'b0;
    #1;
    check("midrst_x", 32'(topLeftX), 200);
    check("midrst_y", 32'(topLeftY), 240);
    check("midrst_idle", 32'(ballIdle), 1);
    check("midrst_pulse", 32'(shotAccepted), 0);
    tick();
    resetN = 1'b1;
    modelReset();
    tick();

    shoot("slow", 1, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      frame("slow_f");
      check("slow_moving", 32'(ballIdle), 0);
    end
    frame("slow_last");
    check("slow_stop_idle", 32'(ballIdle), 1);
    check("slow_stop_x", 32'(topLeftX), 200);
    check("slow_stop_y", 32'(topLeftY), 240);

    shoot("bounce", -200, 200, 1'b0);
    for (int i = 0; i < 120; i++) begin
      frame("bounce_f");
    end

    ballInPocket = 1'b1;
    startOfFrame = 1'b1;
    velocityWriteEnable = 1'b1;
    newVelocityX = 11'sd50;
    newVelocityY = 11'sd50;
    tick();
    ballInPocket = 1'b0;
    startOfFrame = 1'b0;
    velocityWriteEnable = 1'b0;
    newVelocityX = '0;
    newVelocityY = '0;
    modelReset();
    check("pocket_x", 32'(topLeftX), 200);
    check("pocket_y", 32'(topLeftY), 240);
    check("pocket_idle", 32'(ballIdle), 1);
    check("pocket_pulse", 32'(shotAccepted), 0);
    tick();
    check("pocket_pulse_after", 32'(shotAccepted), 0);

    shoot("after_pocket", 0, 5, 1'b0);
    frame("after_pocket_f1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
